// File: rtl/srv_line_fill_if.sv
// Bus bundle for the line-refill engine.
// It carries the cache miss port and the word-wide instruction memory port.
interface srv_line_fill_if;
   logic         fill_req_i;
   logic [31:0]  fill_addr_i;
   logic         fill_rsp_o;
   logic [127:0] fill_data_o;
   logic         mem_req_o;
   logic [31:0]  mem_addr_o;
   logic         mem_ack_i;
   logic [31:0]  mem_rdata_i;
   logic         busy_o;
   logic         fill_err_o;

   modport slave (
      input  fill_req_i, fill_addr_i, mem_ack_i, mem_rdata_i,
      output fill_rsp_o, fill_data_o, mem_req_o, mem_addr_o, busy_o, fill_err_o
   );

   modport master (
      output fill_req_i, fill_addr_i, mem_ack_i, mem_rdata_i,
      input  fill_rsp_o, fill_data_o, mem_req_o, mem_addr_o, busy_o, fill_err_o
   );
endinterface

// File: rtl/srv_line_fill.sv
// Line-refill engine: fetches four sequential words and returns a 128-bit line.
// A per-beat watchdog pads lost beats with NOP_WORD and raises a sticky error.
module srv_line_fill #(
   parameter int          BYTE_ADDR   = 0,
   parameter int          TIMEOUT_CYC = 64,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic           clk,
   input  logic           rst_n,
   srv_line_fill_if.slave bus
);

   localparam int WDOG_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT_CYC > 0) ? WDOG_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [1:0]          beat_r, beat_nxt_s;
   logic [WDOG_W-1:0]   wdog_r, wdog_nxt_s;
   logic [31:0]         base_r, base_nxt_s;
   logic [127:0]        line_r, line_nxt_s;
   logic [127:0]        data_r, data_nxt_s;
   logic [31:0]         addr_r, addr_nxt_s;
   logic                err_r, err_nxt_s;
   logic                rsp_r, rsp_nxt_s;
   logic                req_r, busy_r;

   // The byte-address form drops word-address bits [31:30].
   function automatic logic [31:0] fmt_addr(input logic [31:0] word_addr);
      if (BYTE_ADDR != 0) begin
         fmt_addr = {word_addr[29:0], 2'b00};
      end else begin
         fmt_addr = word_addr;
      end
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt_s = state_r;
      beat_nxt_s  = beat_r;
      wdog_nxt_s  = wdog_r;
      base_nxt_s  = base_r;
      line_nxt_s  = line_r;
      data_nxt_s  = data_r;
      addr_nxt_s  = addr_r;
      err_nxt_s   = err_r;
      rsp_nxt_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.fill_req_i) begin
               state_nxt_s = ST_REQ;
               base_nxt_s  = {bus.fill_addr_i[31:2], 2'b00};
               beat_nxt_s  = 2'd0;
               wdog_nxt_s  = '0;
               line_nxt_s  = '0;
               addr_nxt_s  = fmt_addr({bus.fill_addr_i[31:2], 2'b00});
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.mem_ack_i) begin
               line_nxt_s[{beat_r, 5'b00000} +: 32] = bus.mem_rdata_i;
               wdog_nxt_s = '0;
               if (beat_r == 2'd3) begin
                  state_nxt_s = ST_RSP;
                  rsp_nxt_s   = 1'b1;
                  data_nxt_s  = line_nxt_s;
               end else begin
                  beat_nxt_s = beat_r + 2'd1;
                  addr_nxt_s = fmt_addr({base_r[31:2], beat_r + 2'd1});
               end
            end else if ((TIMEOUT_CYC != 0) && (wdog_r == WDOG_LAST)) begin
               // Dead memory: pad the current and all later beats.
               for (int i = 0; i < 4; i++) begin
                  line_nxt_s[32*i +: 32] = (2'(i) >= beat_r) ? NOP_WORD : line_r[32*i +: 32];
               end
               err_nxt_s   = 1'b1;
               wdog_nxt_s  = '0;
               state_nxt_s = ST_RSP;
               rsp_nxt_s   = 1'b1;
               data_nxt_s  = line_nxt_s;
            end else if (TIMEOUT_CYC != 0) begin
               wdog_nxt_s = wdog_r + WDOG_ONE;
            end else begin
               wdog_nxt_s = wdog_r;
            end
         end
         ST_RSP: begin
            state_nxt_s = ST_IDLE;
            wdog_nxt_s  = '0;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            wdog_nxt_s  = '0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_r <= 2'd0;
         wdog_r <= '0;
         base_r <= 32'h0000_0000;
         line_r <= '0;
         data_r <= '0;
         addr_r <= 32'h0000_0000;
         err_r  <= 1'b0;
         rsp_r  <= 1'b0;
         req_r  <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         beat_r <= beat_nxt_s;
         wdog_r <= wdog_nxt_s;
         base_r <= base_nxt_s;
         line_r <= line_nxt_s;
         data_r <= data_nxt_s;
         addr_r <= addr_nxt_s;
         err_r  <= err_nxt_s;
         rsp_r  <= rsp_nxt_s;
         req_r  <= (state_nxt_s == ST_REQ);
         busy_r <= (state_nxt_s != ST_IDLE);
      end
   end

   assign bus.fill_rsp_o  = rsp_r;
   assign bus.fill_data_o = data_r;
   assign bus.mem_req_o   = req_r;
   assign bus.mem_addr_o  = addr_r;
   assign bus.busy_o      = busy_r;
   assign bus.fill_err_o  = err_r;

endmodule

// File: tb/tb_srv_line_fill.sv
// Directed bench for srv_line_fill: word- and byte-address instances share one stimulus stream.
module tb_srv_line_fill;

   localparam logic [31:0] XOR_K = 32'hA5A5_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   logic exp_err  = 1'b0;
   logic [31:0]  addr_q[$];
   logic [127:0] line_q[$];

   always #5 clk = ~clk;

   srv_line_fill_if fw();
   srv_line_fill_if fb();

   assign fb.fill_req_i  = fw.fill_req_i;
   assign fb.fill_addr_i = fw.fill_addr_i;
   assign fb.mem_ack_i   = fw.mem_ack_i;
   assign fb.mem_rdata_i = fw.mem_rdata_i;

   srv_line_fill #(.BYTE_ADDR(0), .TIMEOUT_CYC(8), .NOP_WORD(32'h0000_0013)) dut_w (
      .clk(clk), .rst_n(rst_n), .bus(fw.slave));

   srv_line_fill #(.BYTE_ADDR(1), .TIMEOUT_CYC(8), .NOP_WORD(32'h0000_0013)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(fb.slave));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One fill; beats from dead_from onward are never acked, pulse_beat injects a stray request.
   task automatic do_fill(input logic [31:0] addr, input int w0, input int w1, input int w2,
                          input int w3, input int dead_from, input int pulse_beat);
      logic [31:0]  base;
      logic [31:0]  ea;
      logic [127:0] el;
      int           waits[4];
      int           nw;
      logic         ack;
      waits = '{w0, w1, w2, w3};
      base  = {addr[31:2], 2'b00};
      el    = '0;
      for (int i = 0; i < 4; i++) begin
         addr_q.push_back(base + 32'(i));
         el[32*i +: 32] = (i >= dead_from) ? NOP : ((base + 32'(i)) ^ XOR_K);
      end
      line_q.push_back(el);
      if (dead_from < 4) exp_err = 1'b1;
      fw.fill_req_i  = 1'b1;
      fw.fill_addr_i = addr;
      @(negedge clk);
      fw.fill_req_i  = 1'b0;
      fw.fill_addr_i = 32'hDEAD_BEEF;
      for (int b = 0; b < 4; b++) begin
         ea = addr_q.pop_front();
         nw = (b >= dead_from) ? 8 : waits[b] + 1;
         for (int k = 0; k < nw; k++) begin
            check("beat_ctrl", {125'd0, fw.mem_req_o, fw.fill_rsp_o, fw.busy_o}, 128'd5);
            check("beat_addr", {96'd0, fw.mem_addr_o}, {96'd0, ea});
            check("beat_addr_byte", {96'd0, fb.mem_addr_o}, {96'd0, ea[29:0], 2'b00});
            ack = (b < dead_from) && (k == nw - 1);
            fw.mem_ack_i   = ack;
            fw.mem_rdata_i = ack ? (ea ^ XOR_K) : 32'h0BAD_F00D;
            if (b == pulse_beat && k == 0) begin
               fw.fill_req_i  = 1'b1;
               fw.fill_addr_i = addr + 32'h0000_0100;
            end
            @(negedge clk);
            fw.mem_ack_i  = 1'b0;
            fw.fill_req_i = 1'b0;
         end
         if (b >= dead_from) break;
      end
      addr_q.delete();
      el = line_q.pop_front();
      check("rsp_ctrl", {125'd0, fw.fill_rsp_o, fw.busy_o, fw.mem_req_o}, 128'd6);
      check("rsp_data", fw.fill_data_o, el);
      check("rsp_data_byte", fb.fill_data_o, el);
      check("rsp_err", {127'd0, fw.fill_err_o}, {127'd0, exp_err});
      @(negedge clk);
      check("post_rsp_ctrl", {125'd0, fw.fill_rsp_o, fw.busy_o, fw.mem_req_o}, 128'd0);
      check("post_rsp_ctrl_byte", {125'd0, fb.fill_rsp_o, fb.busy_o, fb.mem_req_o}, 128'd0);
      check("data_hold", fw.fill_data_o, el);
   endtask

   initial begin
      rst_n          = 1'b0;
      fw.fill_req_i  = 1'b0;
      fw.fill_addr_i = 32'h0000_0000;
      fw.mem_ack_i   = 1'b0;
      fw.mem_rdata_i = 32'h0000_0000;
      repeat (2) @(negedge clk);
      check("reset_ctrl", {124'd0, fw.fill_rsp_o, fw.mem_req_o, fw.busy_o, fw.fill_err_o}, 128'd0);
      check("reset_data", fw.fill_data_o, 128'd0);
      check("reset_addr", {96'd0, fw.mem_addr_o}, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Stray ack while idle must not start anything.
      fw.mem_ack_i   = 1'b1;
      fw.mem_rdata_i = 32'h1234_5678;
      @(negedge clk);
      fw.mem_ack_i = 1'b0;
      check("idle_ack", {126'd0, fw.busy_o, fw.fill_rsp_o}, 128'd0);

      do_fill(32'h0000_0041, 0, 0, 0, 0, 4, -1);
      do_fill(32'h0000_1000, 0, 3, 1, 7, 4, -1);
      do_fill(32'h0000_0104, 0, 0, 0, 0, 4, -1);
      do_fill(32'h0000_2000, 0, 0, 0, 0, 2, -1);
      do_fill(32'h0000_2010, 1, 0, 2, 0, 4, -1);
      do_fill(32'h0000_3000, 0, 0, 2, 0, 4, 2);

      // Reset in the middle of beat 1.
      fw.fill_req_i  = 1'b1;
      fw.fill_addr_i = 32'h0000_0200;
      @(negedge clk);
      fw.fill_req_i  = 1'b0;
      fw.mem_ack_i   = 1'b1;
      fw.mem_rdata_i = 32'h0000_0200 ^ XOR_K;
      @(negedge clk);
      fw.mem_ack_i = 1'b0;
      check("beat1_req", {127'd0, fw.mem_req_o}, 128'd1);
      check("beat1_addr", {96'd0, fw.mem_addr_o}, 128'h201);
      #2 rst_n = 1'b0;
      #1;
      check("rst_drop", {124'd0, fw.mem_req_o, fw.busy_o, fb.mem_req_o, fb.busy_o}, 128'd0);
      check("rst_err_clear", {127'd0, fw.fill_err_o}, 128'd0);
      @(negedge clk);
      check("rst_no_rsp", {126'd0, fw.fill_rsp_o, fb.fill_rsp_o}, 128'd0);
      rst_n   = 1'b1;
      exp_err = 1'b0;
      @(negedge clk);
      check("after_rst_idle", {126'd0, fw.fill_rsp_o, fw.busy_o}, 128'd0);
      do_fill(32'h0000_0300, 0, 1, 0, 0, 4, -1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
